// File: rtl/pipeline_hazard_ctrl.sv
// ID/EX pipeline sequencer: RAW hazard stall, taken-branch flush, destination
// scoreboard and saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned HAZ_DEPTH    = 3,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_aa,
    input  logic [4:0]       id_ba,
    input  logic             id_use_a,
    input  logic             id_use_b,
    input  logic [4:0]       id_da,
    input  logic             id_rw,
    input  logic             ex_br_taken,
    output logic             pc_hold,
    output logic             if_id_hold,
    output logic             id_ex_bubble,
    output logic             flush_if_id,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    state_t     state_q;
    logic [1:0] flush_ctr;

    logic       sb_v  [HAZ_DEPTH];
    logic       sb_rw [HAZ_DEPTH];
    logic [4:0] sb_da [HAZ_DEPTH];

    logic match_a;
    logic match_b;
    logic hazard;
    logic flushing;
    logic issue;

    // Register 0 is hard-wired, so it can never be the subject of a RAW hazard.
    always_comb begin
        match_a = 1'b0;
        match_b = 1'b0;
        for (int unsigned i = 0; i < HAZ_DEPTH; i++) begin
            if (sb_v[i] && sb_rw[i] && (sb_da[i] == id_aa)) match_a = 1'b1;
            if (sb_v[i] && sb_rw[i] && (sb_da[i] == id_ba)) match_b = 1'b1;
        end
        if (id_aa == '0) match_a = 1'b0;
        if (id_ba == '0) match_b = 1'b0;
    end

    assign hazard   = id_valid & ((id_use_a & match_a) | (id_use_b & match_b));
    assign flushing = ex_br_taken | (flush_ctr != '0);
    assign issue    = id_valid & ~hazard & ~flushing;

    // Flush wins over hazard: PC must be free to take the branch target.
    assign flush_if_id  = ~reset & flushing;
    assign id_ex_bubble = ~reset & (flushing | hazard);
    assign pc_hold      = ~reset & ~flushing & hazard;
    assign if_id_hold   = ~reset & ~flushing & hazard;

    assign state = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            flush_ctr <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            for (int unsigned i = 0; i < HAZ_DEPTH; i++) begin
                sb_v[i]  <= 1'b0;
                sb_rw[i] <= 1'b0;
                sb_da[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < HAZ_DEPTH; i++) begin
                sb_v[i]  <= sb_v[i-1];
                sb_rw[i] <= sb_rw[i-1];
                sb_da[i] <= sb_da[i-1];
            end
            sb_v[0]  <= issue;
            sb_rw[0] <= issue & id_rw;
            sb_da[0] <= issue ? id_da : 5'd0;

            if (ex_br_taken)
                flush_ctr <= 2'(FLUSH_CYCLES - 1);
            else if (flush_ctr != '0)
                flush_ctr <= flush_ctr - 2'd1;

            if (ex_br_taken) begin
                state_q <= ST_FLUSH;
            end else begin
                case (state_q)
                    ST_RUN:   if (hazard)            state_q <= ST_STALL;
                    ST_STALL: if (!hazard)           state_q <= ST_RUN;
                    ST_FLUSH: if (flush_ctr == '0)   state_q <= ST_RUN;
                    default:                         state_q <= ST_RUN;
                endcase
            end

            if (hazard && !flushing && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (ex_br_taken && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, random stimulus against
// an issue-history reference model, and counter saturation on a CNT_W=4 copy.
module tb_pipeline_hazard_ctrl;

    localparam int HAZ = 3;
    localparam int FC  = 2;

    logic        clk = 1'b0;
    logic        reset, id_valid, id_use_a, id_use_b, id_rw, ex_br_taken;
    logic [4:0]  id_aa, id_ba, id_da;
    logic        pc_hold, if_id_hold, id_ex_bubble, flush_if_id;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_pc_hold, s_if_id_hold, s_id_ex_bubble, s_flush_if_id;
    logic [1:0]  s_state;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.HAZ_DEPTH(HAZ), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_aa(id_aa), .id_ba(id_ba),
        .id_use_a(id_use_a), .id_use_b(id_use_b), .id_da(id_da), .id_rw(id_rw),
        .ex_br_taken(ex_br_taken), .pc_hold(pc_hold), .if_id_hold(if_id_hold),
        .id_ex_bubble(id_ex_bubble), .flush_if_id(flush_if_id), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.HAZ_DEPTH(HAZ), .FLUSH_CYCLES(FC), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_aa(id_aa), .id_ba(id_ba),
        .id_use_a(id_use_a), .id_use_b(id_use_b), .id_da(id_da), .id_rw(id_rw),
        .ex_br_taken(ex_br_taken), .pc_hold(s_pc_hold), .if_id_hold(s_if_id_hold),
        .id_ex_bubble(s_id_ex_bubble), .flush_if_id(s_flush_if_id), .state(s_state),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct {
        logic       rst, v, ua, ub, rw, br;
        logic [4:0] aa, ba, da;
        logic [3:0] ctl;   // {pc_hold, if_id_hold, id_ex_bubble, flush_if_id}
        logic [1:0] st;
        int         stl, fl;
    } vec_t;

    typedef struct {
        logic [4:0] da;
        logic       rw;
        int         c;
    } wr_t;

    int  checks = 0;
    int  errors = 0;
    bit  chk_en = 0;

    // Reference model: history of issued writers with issue cycle numbers.
    wr_t        hist[$];
    int         t_cyc = 0;
    int         last_br = -1000;
    bit         prev_rst = 1;
    bit         prev_haz = 0;
    logic [1:0] prev_state = 2'b00;
    int         n_stall = 0, n_flush = 0;
    bit         m_haz, m_fl;
    logic [1:0] m_state;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit hit(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (hist[i])
            if (hist[i].rw && hist[i].da == r && (t_cyc - hist[i].c) <= HAZ) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic model_eval();
        logic [3:0] e_ctl;
        m_fl  = ex_br_taken || ((t_cyc - last_br) < FC);
        m_haz = id_valid && ((id_use_a && hit(id_aa)) || (id_use_b && hit(id_ba)));
        if (prev_rst)                                        m_state = 2'b00;
        else if ((t_cyc - last_br) >= 1 && (t_cyc - last_br) <= FC) m_state = 2'b10;
        else if (prev_haz && prev_state != 2'b10)            m_state = 2'b01;
        else                                                 m_state = 2'b00;
        if (reset)      e_ctl = 4'b0000;
        else if (m_fl)  e_ctl = 4'b0011;
        else if (m_haz) e_ctl = 4'b1110;
        else            e_ctl = 4'b0000;
        if (chk_en) begin
            check("model_ctl", {pc_hold, if_id_hold, id_ex_bubble, flush_if_id}, e_ctl);
            check("model_state", state, m_state);
            check("model_stall_cnt", stall_cnt, sat(n_stall, 65535));
            check("model_flush_cnt", flush_cnt, sat(n_flush, 65535));
            check("model_sat_ctl", {s_pc_hold, s_if_id_hold, s_id_ex_bubble, s_flush_if_id}, e_ctl);
            check("model_sat_stall_cnt", s_stall_cnt, sat(n_stall, 15));
            check("model_sat_flush_cnt", s_flush_cnt, sat(n_flush, 15));
        end
    endtask

    task automatic model_update();
        if (reset) begin
            hist.delete();
            last_br    = -1000;
            n_stall    = 0;
            n_flush    = 0;
            prev_rst   = 1;
            prev_haz   = 0;
            prev_state = 2'b00;
        end else begin
            if (m_haz && !m_fl) n_stall++;
            if (ex_br_taken) begin
                n_flush++;
                last_br = t_cyc;
            end
            if (id_valid && !m_haz && !m_fl) hist.push_back('{id_da, id_rw, t_cyc});
            while (hist.size() > 0 && (t_cyc + 1 - hist[0].c) > HAZ) void'(hist.pop_front());
            prev_rst   = 0;
            prev_haz   = m_haz;
            prev_state = m_state;
        end
        t_cyc++;
    endtask

    task automatic cycle(input vec_t vv, input bit tchk);
        @(negedge clk);
        reset = vv.rst; id_valid = vv.v; id_aa = vv.aa; id_use_a = vv.ua;
        id_ba = vv.ba; id_use_b = vv.ub; id_da = vv.da; id_rw = vv.rw; ex_br_taken = vv.br;
        #1;
        model_eval();
        if (tchk) begin
            check("vec_ctl", {pc_hold, if_id_hold, id_ex_bubble, flush_if_id}, vv.ctl);
            check("vec_state", state, vv.st);
            check("vec_stall_cnt", stall_cnt, vv.stl);
            check("vec_flush_cnt", flush_cnt, vv.fl);
        end
        @(posedge clk);
        model_update();
    endtask

    function automatic vec_t mk(input int rst, v, aa, ua, ba, ub, da, rw, br, ctl, st, stl, fl);
        vec_t r;
        r.rst = 1'(rst); r.v = 1'(v); r.aa = 5'(aa); r.ua = 1'(ua); r.ba = 5'(ba);
        r.ub = 1'(ub); r.da = 5'(da); r.rw = 1'(rw); r.br = 1'(br);
        r.ctl = 4'(ctl); r.st = 2'(st); r.stl = stl; r.fl = fl;
        return r;
    endfunction

    vec_t tbl[$];

    task automatic raw_pair(input int stalls);
        cycle(mk(0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0), 1'b0);
        for (int k = 0; k <= stalls; k++)
            cycle(mk(0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    endtask

    initial begin
        //          rst v aa ua ba ub da rw br ctl st stl fl
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 5, 1, 0,  0, 0, 0, 0));   // writer r5
        tbl.push_back(mk(0, 1, 5, 1, 0, 0, 6, 1, 0, 14, 0, 0, 0));   // RAW on r5: 3 stalls
        tbl.push_back(mk(0, 1, 5, 1, 0, 0, 6, 1, 0, 14, 1, 1, 0));
        tbl.push_back(mk(0, 1, 5, 1, 0, 0, 6, 1, 0, 14, 1, 2, 0));
        tbl.push_back(mk(0, 1, 5, 1, 0, 0, 6, 1, 0,  0, 1, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 3, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0,  0, 0, 3, 0));   // writer to r0
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 7, 0, 0,  0, 0, 3, 0));   // read r0; non-writing r7
        tbl.push_back(mk(0, 1, 7, 1, 0, 0, 8, 1, 0,  0, 0, 3, 0));   // read r7 after RW=0
        tbl.push_back(mk(0, 1, 0, 0, 8, 0, 9, 1, 0,  0, 0, 3, 0));   // BA match, use_b=0
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 3, 0));   // writer r10
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 11, 0, 0, 0, 0, 3, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 12, 0, 0, 0, 0, 3, 0));
        tbl.push_back(mk(0, 1, 0, 0, 10, 1, 13, 0, 0, 14, 0, 3, 0)); // gap: 1 stall
        tbl.push_back(mk(0, 1, 0, 0, 10, 1, 13, 0, 0, 0, 1, 4, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 4, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 14, 1, 0, 0, 0, 4, 0));   // writer r14
        tbl.push_back(mk(0, 1, 14, 1, 0, 0, 15, 1, 0, 14, 0, 4, 0)); // stall
        tbl.push_back(mk(0, 1, 14, 1, 0, 0, 15, 1, 1, 3, 1, 5, 0));  // branch while stalled
        tbl.push_back(mk(0, 1, 14, 1, 0, 0, 15, 1, 0, 3, 2, 5, 1));
        tbl.push_back(mk(0, 1, 15, 1, 0, 0, 16, 1, 0, 0, 2, 5, 1));  // squashed r15 not tracked
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 5, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 3, 1, 0,  0, 0, 5, 1));   // writer r3
        tbl.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 14, 0, 5, 1));
        tbl.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 14, 1, 6, 1));
        tbl.push_back(mk(1, 1, 3, 1, 0, 0, 0, 0, 0,  0, 1, 7, 1));   // reset mid-stall
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0));   // scoreboard cleared

        cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        chk_en = 1;
        foreach (tbl[i]) cycle(tbl[i], 1'b1);

        for (int n = 0; n < 3000; n++) begin
            vec_t r;
            r = mk(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                   $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 1),
                   ($urandom_range(0, 7) == 0), 0, 0, 0, 0);
            cycle(r, 1'b0);
        end

        cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        for (int p = 0; p < 7; p++) raw_pair(3);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        #2;
        check("sat_stall_cnt", s_stall_cnt, 15);
        check("full_stall_cnt", stall_cnt, 21);
        for (int p = 0; p < 2; p++) raw_pair(3);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        #2;
        check("sat_stall_hold", s_stall_cnt, 15);
        check("full_stall_cnt2", stall_cnt, 27);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
